// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Read-side consumer of the 8-bit capture FIFO.  Pops one byte at a time
// (allowing for the FIFO's one-cycle registered read latency) and sends it
// on the host link as an asynchronous UART frame, LSB first:
//   start(0), d0..d7, [even parity], STOP_BITS x stop(1)
// Every bit lasts exactly CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   PARITY_EN     1 = append an even parity bit after the data bits
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low (0 = reset)
//   enable      1 = allowed to start new frames
//   fifo_empty  FIFO empty flag, sampled only while idle
//   fifo_data   FIFO registered read data, valid the cycle after a pop
//   fifo_rd_en  FIFO pop request (registered, one cycle per byte)
//   tx          UART serial line, idle high (registered)
//   busy        1 while a pop or frame is in progress (registered)
//   byte_done   one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic            tx_q, tx_d;
    logic            rd_en_q, rd_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            bit_end;

    // Last cycle of the current bit period; the counter wraps here so each
    // bit is exactly CLKS_PER_BIT cycles with no accumulated drift.
    assign bit_end = (cnt_q == CNT_LAST);

    // State register plus the registered copies of every output.  Reset
    // aborts any frame in flight and drives the line high straight away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.  bit_q indexes data bits in DATA and counts stop
    // bits in STOP.  Outputs are derived from the *next* state so that the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d  = fifo_data;
                parity_d = ^fifo_data;
                cnt_d    = '0;
                bit_d    = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase

        rd_en_d = (state_d == S_POP);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign byte_done  = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Two instances share one clock: dut0 (4 clk/bit, no parity, 1 stop bit)
// and dut1 (4 clk/bit, even parity, 2 stop bits).  Each has a small FIFO
// model with one-cycle registered read latency.  Expected line waveforms
// come from frameModel, which builds the frame cycle by cycle from the
// UART framing rules.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int BIT_CLKS = 4;
    localparam int FRAME0   = (1 + 8 + 0 + 1) * BIT_CLKS;
    localparam int FRAME1   = (1 + 8 + 1 + 2) * BIT_CLKS;

    logic       clk;
    logic [1:0] rstW;
    logic [1:0] enableW;
    logic [1:0] emptyW;
    logic [1:0] rdEnW;
    logic [1:0] txW;
    logic [1:0] busyW;
    logic [1:0] doneW;
    logic [7:0] fifoData0;
    logic [7:0] fifoData1;

    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    logic [7:0] expQ0[$];
    logic [7:0] expQ1[$];
    logic [1:0] popPending;
    int         popCount0;
    int         popCount1;

    int checkCount;
    int errorCount;

    fifo_uart_tx #(
        .CLKS_PER_BIT(BIT_CLKS),
        .PARITY_EN   (1'b0),
        .STOP_BITS   (1)
    ) dut0 (
        .clk       (clk),
        .rst       (rstW[0]),
        .enable    (enableW[0]),
        .fifo_empty(emptyW[0]),
        .fifo_data (fifoData0),
        .fifo_rd_en(rdEnW[0]),
        .tx        (txW[0]),
        .busy      (busyW[0]),
        .byte_done (doneW[0])
    );

    fifo_uart_tx #(
        .CLKS_PER_BIT(BIT_CLKS),
        .PARITY_EN   (1'b1),
        .STOP_BITS   (2)
    ) dut1 (
        .clk       (clk),
        .rst       (rstW[1]),
        .enable    (enableW[1]),
        .fifo_empty(emptyW[1]),
        .fifo_data (fifoData1),
        .fifo_rd_en(rdEnW[1]),
        .tx        (txW[1]),
        .busy      (busyW[1]),
        .byte_done (doneW[1])
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Latch pop requests mid-cycle so the FIFO model acts on the value
    // present at the following rising edge.
    always @(negedge clk) begin
        popPending = rdEnW;
    end

    // FIFO model: a pop seen at a rising edge presents the head byte just
    // after that edge (valid the whole next cycle); the empty flag is
    // registered from the queue depth.
    always @(posedge clk) begin
        #1;
        if (popPending[0]) begin
            popCount0++;
            if (fq0.size() > 0) fifoData0 = fq0.pop_front();
        end
        if (popPending[1]) begin
            popCount1++;
            if (fq1.size() > 0) fifoData1 = fq1.pop_front();
        end
        emptyW[0] = (fq0.size() == 0);
        emptyW[1] = (fq1.size() == 0);
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected line level for every cycle of one frame; bit k of the
    // result is the tx level k cycles after the start bit begins.
    function automatic logic [63:0] frameModel(input logic [7:0] b, input int parityEn,
                                               input int stopBits);
        logic [63:0] w;
        int          nBits;
        int          idx;
        w     = '1;
        nBits = 9 + parityEn + stopBits;
        for (int k = 0; k < nBits * BIT_CLKS; k++) begin
            idx = k / BIT_CLKS;
            if (idx == 0)                        w[k] = 1'b0;
            else if (idx <= 8)                   w[k] = b[idx-1];
            else if (parityEn != 0 && idx == 9)  w[k] = ^b;
            else                                 w[k] = 1'b1;
        end
        return w;
    endfunction

    task automatic pushByte(input int d, input logic [7:0] b);
        if (d == 0) begin
            fq0.push_back(b);
            expQ0.push_back(b);
        end else begin
            fq1.push_back(b);
            expQ1.push_back(b);
        end
    endtask

    // Waits (bounded) for a start bit, then records len cycles of tx.
    // Also reports the idle-high cycles and byte_done pulses seen before it.
    task automatic captureFrame(input int d, input int len, output logic [63:0] wave,
                                output int waitCycles, output int doneInWait, output bit ok);
        wave       = '1;
        waitCycles = 0;
        doneInWait = 0;
        ok         = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (txW[d] === 1'b0) begin
                ok = 1'b1;
            end else begin
                waitCycles++;
                if (doneW[d] === 1'b1) doneInWait++;
            end
        end
        if (ok) begin
            wave[0] = 1'b0;
            for (int k = 1; k < len; k++) begin
                @(negedge clk);
                wave[k] = txW[d];
            end
        end
    endtask

    task automatic test_reset();
        pushByte(0, 8'hA5);
        enableW[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkCount++;
            if (txW[0] !== 1'b1 || rdEnW[0] !== 1'b0 || busyW[0] !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL reset_hold: tx=%b rd_en=%b busy=%b, expected tx=1 rd_en=0 busy=0",
                         txW[0], rdEnW[0], busyW[0]);
            end
        end
        rstW[0] = 1'b1;
        @(negedge clk);
        checkCount++;
        if (rdEnW[0] !== 1'b1 || busyW[0] !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL reset_first_pop: rd_en=%b busy=%b, expected rd_en=1 busy=1",
                     rdEnW[0], busyW[0]);
        end
        @(negedge clk);
        checkCount++;
        if (rdEnW[0] !== 1'b0 || popCount0 !== 1) begin
            errorCount++;
            $display("[TB] FAIL reset_pop_once: rd_en=%b pops=%0d, expected rd_en=0 pops=1",
                     rdEnW[0], popCount0);
        end
    endtask

    task automatic test_single_byte();
        logic [63:0] wave;
        logic [63:0] expWave;
        int          w;
        int          dn;
        bit          ok;
        expWave = frameModel(expQ0.pop_front(), 0, 1);
        captureFrame(0, FRAME0, wave, w, dn, ok);
        checkCount++;
        if (!ok) begin
            errorCount++;
            $display("[TB] FAIL single_start: start bit seen=%0d, expected 1", ok);
        end
        checkCount++;
        if (wave !== expWave) begin
            errorCount++;
            $display("[TB] FAIL single_frame: got %h expected %h", wave, expWave);
        end
        @(negedge clk);
        checkCount++;
        if (doneW[0] !== 1'b1 || txW[0] !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL single_done: byte_done=%b tx=%b, expected 1 1", doneW[0], txW[0]);
        end
        @(negedge clk);
        checkCount++;
        if (doneW[0] !== 1'b0 || busyW[0] !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL single_idle: byte_done=%b busy=%b, expected 0 0", doneW[0], busyW[0]);
        end
    endtask

    task automatic runFrames(input int d, input int n, input string name);
        logic [63:0] wave;
        logic [63:0] expWave;
        int          w;
        int          dn;
        bit          ok;
        for (int f = 0; f < n; f++) begin
            if (d == 0) expWave = frameModel(expQ0.pop_front(), 0, 1);
            else        expWave = frameModel(expQ1.pop_front(), 1, 2);
            captureFrame(d, (d == 0) ? FRAME0 : FRAME1, wave, w, dn, ok);
            checkCount++;
            if (!ok || wave !== expWave) begin
                errorCount++;
                $display("[TB] FAIL %s_frame%0d: got %h expected %h (start seen %0d)",
                         name, f, wave, expWave, ok);
            end
            if (f > 0) begin
                checkCount++;
                if (w !== 3 || dn !== 1) begin
                    errorCount++;
                    $display("[TB] FAIL %s_gap%0d: high cycles=%0d done pulses=%0d, expected 3 1",
                             name, f, w, dn);
                end
            end
            if (d == 1 && f < 2) begin
                checkCount++;
                if (wave[36] !== (f == 0)) begin
                    errorCount++;
                    $display("[TB] FAIL %s_parity%0d: got %b expected %b", name, f, wave[36], (f == 0));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int popBefore;
        int lowCnt;
        int rdCnt;
        popBefore = popCount0;
        pushByte(0, 8'h11);
        pushByte(0, 8'h22);
        pushByte(0, 8'h33);
        runFrames(0, 3, "b2b");
        lowCnt = 0;
        rdCnt  = 0;
        repeat (20) begin
            @(negedge clk);
            if (txW[0] !== 1'b1) lowCnt++;
            if (rdEnW[0] !== 1'b0) rdCnt++;
        end
        checkCount++;
        if (lowCnt !== 0 || rdCnt !== 0 || popCount0 - popBefore !== 3 || busyW[0] !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL b2b_drain: low=%0d rd_en=%0d pops=%0d busy=%b, expected 0 0 3 0",
                     lowCnt, rdCnt, popCount0 - popBefore, busyW[0]);
        end
    endtask

    task automatic test_enable_drop();
        logic [63:0] wave;
        logic [63:0] expWave;
        logic [7:0]  nextByte;
        int          w;
        int          dn;
        bit          ok;
        int          popBefore;
        int          lowCnt;
        int          rdCnt;
        nextByte    = 8'($urandom);
        nextByte[5] = 1'b0;
        popBefore   = popCount0;
        pushByte(0, 8'h5A);
        pushByte(0, nextByte);
        expWave = frameModel(expQ0.pop_front(), 0, 1);
        fork
            captureFrame(0, FRAME0, wave, w, dn, ok);
            begin
                for (int c = 0; c < 300; c++) begin
                    @(negedge clk);
                    if (txW[0] === 1'b0) break;
                end
                repeat (4 * BIT_CLKS + 1) @(negedge clk);
                enableW[0] = 1'b0;
            end
        join
        checkCount++;
        if (!ok || wave !== expWave) begin
            errorCount++;
            $display("[TB] FAIL en_drop_frame: got %h expected %h", wave, expWave);
        end
        lowCnt = 0;
        rdCnt  = 0;
        repeat (30) begin
            @(negedge clk);
            if (txW[0] !== 1'b1) lowCnt++;
            if (rdEnW[0] !== 1'b0) rdCnt++;
        end
        checkCount++;
        if (lowCnt !== 0 || rdCnt !== 0 || popCount0 - popBefore !== 1 || busyW[0] !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL en_drop_idle: low=%0d rd_en=%0d pops=%0d busy=%b, expected 0 0 1 0",
                     lowCnt, rdCnt, popCount0 - popBefore, busyW[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] wave;
        logic [63:0] expWave;
        logic [7:0]  aborted;
        int          w;
        int          dn;
        bit          ok;
        bit          seen;
        aborted    = expQ0.pop_front();
        enableW[0] = 1'b1;
        seen       = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (txW[0] === 1'b0) seen = 1'b1;
        end
        repeat (6 * BIT_CLKS + 1) @(negedge clk);
        checkCount++;
        if (!seen || txW[0] !== aborted[5]) begin
            errorCount++;
            $display("[TB] FAIL midrst_bit5: tx=%b expected %b (start seen %0d)", txW[0], aborted[5], seen);
        end
        #1;
        rstW[0] = 1'b0;
        #1;
        checkCount++;
        if (txW[0] !== 1'b1 || busyW[0] !== 1'b0 || rdEnW[0] !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL midrst_async: tx=%b busy=%b rd_en=%b, expected 1 0 0",
                     txW[0], busyW[0], rdEnW[0]);
        end
        pushByte(0, 8'($urandom));
        repeat (3) @(negedge clk);
        rstW[0] = 1'b1;
        expWave = frameModel(expQ0.pop_front(), 0, 1);
        captureFrame(0, FRAME0, wave, w, dn, ok);
        checkCount++;
        if (!ok || wave !== expWave || w !== 2) begin
            errorCount++;
            $display("[TB] FAIL midrst_restart: got %h wait=%0d expected %h wait=2", wave, w, expWave);
        end
    endtask

    task automatic test_random();
        int popBefore;
        popBefore = popCount0;
        for (int i = 0; i < 4; i++) pushByte(0, 8'($urandom));
        runFrames(0, 4, "rand");
        repeat (4) @(negedge clk);
        checkCount++;
        if (popCount0 - popBefore !== 4 || busyW[0] !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL rand_pops: pops=%0d busy=%b, expected 4 0", popCount0 - popBefore, busyW[0]);
        end
    endtask

    task automatic test_parity();
        int popBefore;
        popBefore = popCount1;
        pushByte(1, 8'h07);
        pushByte(1, 8'h03);
        pushByte(1, 8'($urandom));
        enableW[1] = 1'b1;
        runFrames(1, 3, "parity");
        repeat (4) @(negedge clk);
        checkCount++;
        if (popCount1 - popBefore !== 3 || busyW[1] !== 1'b0 || txW[1] !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL parity_pops: pops=%0d busy=%b tx=%b, expected 3 0 1",
                     popCount1 - popBefore, busyW[1], txW[1]);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        popCount0  = 0;
        popCount1  = 0;
        rstW       = 2'b00;
        enableW    = 2'b00;
        fifoData0  = 8'h00;
        fifoData1  = 8'h00;
        @(negedge clk);
        rstW[1] = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        test_random();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
